// File: rtl/bti_ro_meas_sequencer.sv
// Stress/measure sequencer for one BTI ring-oscillator aging sensor.
// Alternates DC stress with settle + gated edge counting and reports each window's count.
module bti_ro_meas_sequencer #(
    parameter int CNT_W      = 32,
    parameter int TIME_W     = 32,
    parameter int ITER_W     = 16,
    parameter int SETTLE_CYC = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [TIME_W-1:0] cfg_stress_len,
    input  logic [TIME_W-1:0] cfg_gate_len,
    input  logic [ITER_W-1:0] cfg_iters,
    input  logic              ro_in,
    output logic              stress_en,
    output logic              ro_en,
    output logic              busy,
    output logic [CNT_W-1:0]  meas_count,
    output logic [ITER_W-1:0] meas_iter,
    output logic              meas_valid,
    output logic              meas_ovf,
    output logic              done
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (TIME_W > SET_W) ? TIME_W : SET_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STRESS,
        ST_SETTLE,
        ST_GATE,
        ST_REPORT
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   stress_len_q, stress_len_d;
    logic [TIME_W-1:0]   gate_len_q, gate_len_d;
    logic [ITER_W-1:0]   iters_q, iters_d;
    logic [ITER_W-1:0]   iter_idx_q, iter_idx_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                dly_q, dly_d;
    logic                stress_en_q, stress_en_d;
    logic                ro_en_q, ro_en_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    meas_count_q, meas_count_d;
    logic [ITER_W-1:0]   meas_iter_q, meas_iter_d;
    logic                meas_valid_q, meas_valid_d;
    logic                meas_ovf_q, meas_ovf_d;
    logic                done_q, done_d;
    logic                ro_edge;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            stress_len_q <= '0;
            gate_len_q   <= '0;
            iters_q      <= '0;
            iter_idx_q   <= '0;
            timer_q      <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            dly_q        <= 1'b0;
            stress_en_q  <= 1'b0;
            ro_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            meas_count_q <= '0;
            meas_iter_q  <= '0;
            meas_valid_q <= 1'b0;
            meas_ovf_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stress_len_q <= stress_len_d;
            gate_len_q   <= gate_len_d;
            iters_q      <= iters_d;
            iter_idx_q   <= iter_idx_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            dly_q        <= dly_d;
            stress_en_q  <= stress_en_d;
            ro_en_q      <= ro_en_d;
            busy_q       <= busy_d;
            meas_count_q <= meas_count_d;
            meas_iter_q  <= meas_iter_d;
            meas_valid_q <= meas_valid_d;
            meas_ovf_q   <= meas_ovf_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        stress_len_d = stress_len_q;
        gate_len_d   = gate_len_q;
        iters_d      = iters_q;
        iter_idx_d   = iter_idx_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        sync1_d      = ro_in;
        sync2_d      = sync1_q;
        dly_d        = sync2_q;
        meas_count_d = meas_count_q;
        meas_iter_d  = meas_iter_q;
        meas_valid_d = 1'b0;
        meas_ovf_d   = meas_ovf_q;
        done_d       = done_q;
        ro_edge      = sync2_q & ~dly_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    stress_len_d = cfg_stress_len;
                    gate_len_d   = cfg_gate_len;
                    iters_d      = cfg_iters;
                    iter_idx_d   = '0;
                    done_d       = 1'b0;
                    state_d      = (cfg_stress_len == '0) ? ST_SETTLE : ST_STRESS;
                end
            end
            ST_STRESS: begin
                if (timer_q == '0) state_d = ST_SETTLE;
                else               timer_d = timer_q - TMR_W'(1);
            end
            ST_SETTLE: begin
                if (timer_q == '0) state_d = ST_GATE;
                else               timer_d = timer_q - TMR_W'(1);
            end
            ST_GATE: begin
                // Saturate instead of wrapping; a lost edge marks the window as overflowed.
                if (ro_edge) begin
                    if (&cnt_q) ovf_d = 1'b1;
                    else        cnt_d = cnt_q + CNT_W'(1);
                end
                if (timer_q == '0) begin
                    state_d      = ST_REPORT;
                    meas_count_d = cnt_d;
                    meas_ovf_d   = ovf_d;
                    meas_iter_d  = iter_idx_q + ITER_W'(1);
                    meas_valid_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_REPORT: begin
                if ((iters_q != '0) && ((iter_idx_q + ITER_W'(1)) == iters_q)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    iter_idx_d = iter_idx_q + ITER_W'(1);
                    state_d    = (stress_len_q == '0) ? ST_SETTLE : ST_STRESS;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cfg_abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            meas_count_d = meas_count_q;
            meas_iter_d  = meas_iter_q;
            meas_ovf_d   = meas_ovf_q;
            meas_valid_d = 1'b0;
            done_d       = done_q;
        end

        // Each phase loads its own cycle budget (minus one) on entry and counts down to zero.
        if (state_d != state_q) begin
            case (state_d)
                ST_STRESS: timer_d = TMR_W'(stress_len_d) - TMR_W'(1);
                ST_SETTLE: begin
                    timer_d = TMR_W'(SETTLE_CYC - 1);
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
                ST_GATE:   timer_d = (gate_len_q == '0) ? '0 : (TMR_W'(gate_len_q) - TMR_W'(1));
                default:   timer_d = timer_q;
            endcase
        end

        stress_en_d = (state_d == ST_STRESS);
        ro_en_d     = (state_d == ST_SETTLE) || (state_d == ST_GATE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign stress_en  = stress_en_q;
    assign ro_en      = ro_en_q;
    assign busy       = busy_q;
    assign meas_count = meas_count_q;
    assign meas_iter  = meas_iter_q;
    assign meas_valid = meas_valid_q;
    assign meas_ovf   = meas_ovf_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bti_ro_meas_sequencer.sv
// Scoreboard bench for bti_ro_meas_sequencer: per-cycle expected enables/status from a
// schedule model plus a queue of expected reports, checked by an independent monitor.
module tb_bti_ro_meas_sequencer;

    localparam int CNT_W  = 4;
    localparam int TIME_W = 16;
    localparam int ITER_W = 3;
    localparam int SETTLE = 16;
    localparam int NCYC   = 8000;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              cfg_start, cfg_abort;
    logic [TIME_W-1:0] cfg_stress_len, cfg_gate_len;
    logic [ITER_W-1:0] cfg_iters;
    logic              ro_in;
    logic              stress_en, ro_en, busy, meas_valid, meas_ovf, done;
    logic [CNT_W-1:0]  meas_count;
    logic [ITER_W-1:0] meas_iter;

    bti_ro_meas_sequencer #(
        .CNT_W(CNT_W), .TIME_W(TIME_W), .ITER_W(ITER_W), .SETTLE_CYC(SETTLE)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_stress_len(cfg_stress_len), .cfg_gate_len(cfg_gate_len), .cfg_iters(cfg_iters),
        .ro_in(ro_in), .stress_en(stress_en), .ro_en(ro_en), .busy(busy),
        .meas_count(meas_count), .meas_iter(meas_iter), .meas_valid(meas_valid),
        .meas_ovf(meas_ovf), .done(done)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int               cyc;
        logic [CNT_W-1:0] cnt;
        logic [ITER_W-1:0] iter;
        logic             ovf;
    } rep_t;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   reset_at = -10;
    bit   r_pat [NCYC];
    bit   exp_s [NCYC];
    bit   exp_r [NCYC];
    bit   exp_b [NCYC];
    bit   exp_d [NCYC];
    rep_t exp_q [$];

    initial forever begin
        @(posedge ACLK);
        cyc = cyc + 1;
    end

    // r_pat[c] is the ro_in level sampled at the clock edge that ends cycle c.
    initial begin
        ro_in = 1'b0;
        forever begin
            @(negedge ACLK);
            if (cyc < NCYC) ro_in = r_pat[cyc];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
        end
    endtask

    function automatic int count_edges(int lo, int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            if (r_pat[c-2] && !r_pat[c-3]) n++;
        return n;
    endfunction

    task automatic fill_pattern(input int base, input int kind, input int half);
        bit prev = 1'b0;
        for (int c = base; c < NCYC; c++) begin
            if (kind == 0) begin
                r_pat[c] = ((c - base) / half) % 2 == 1;
            end else begin
                if ($urandom_range(0, 3) == 0) prev = ~prev;
                r_pat[c] = prev;
            end
        end
    endtask

    // Start accepted in cycle t0: iteration i occupies P cycles starting at t0+1+i*P.
    task automatic model_run(input int t0, input int s, input int g, input int it,
                             input int nmodel, output int last);
        int gl, per, n, st, rep, e;
        gl   = (g == 0) ? 1 : g;
        per  = s + SETTLE + gl + 1;
        n    = (it == 0) ? nmodel : it;
        last = t0;
        for (int c = t0 + 1; c < NCYC; c++) begin
            exp_s[c] = 0; exp_r[c] = 0; exp_b[c] = 0; exp_d[c] = 0;
        end
        for (int i = 0; i < n; i++) begin
            st  = t0 + 1 + i * per;
            rep = st + s + SETTLE + gl;
            if (rep + 1 >= NCYC) break;
            for (int c = st; c < st + s; c++) exp_s[c] = 1;
            for (int c = st + s; c < rep; c++) exp_r[c] = 1;
            for (int c = st; c <= rep; c++) exp_b[c] = 1;
            e = count_edges(st + s + SETTLE, rep - 1);
            exp_q.push_back('{cyc: rep, cnt: CNT_W'((e > CMAX) ? CMAX : e),
                              iter: ITER_W'((i + 1) % (1 << ITER_W)), ovf: (e > CMAX)});
            last = rep;
        end
        if (it != 0)
            for (int c = last + 1; c < NCYC; c++) exp_d[c] = 1;
    endtask

    task automatic purge_after(input int a);
        for (int i = exp_q.size() - 1; i >= 0; i--)
            if (exp_q[i].cyc > a) exp_q.delete(i);
    endtask

    task automatic applyStimulus(input int s, input int g, input int it, input int kind,
                                 input int half, input int nmodel, output int t0, output int last);
        @(negedge ACLK);
        fill_pattern(cyc + 1, kind, half);
        @(negedge ACLK);
        cfg_stress_len = TIME_W'(s);
        cfg_gate_len   = TIME_W'(g);
        cfg_iters      = ITER_W'(it);
        cfg_start      = 1'b1;
        t0             = cyc;
        model_run(t0, s, g, it, nmodel, last);
        @(negedge ACLK);
        cfg_start = 1'b0;
    endtask

    task automatic start_ignored();
        @(negedge ACLK);
        cfg_stress_len = TIME_W'(3);
        cfg_gate_len   = TIME_W'(7);
        cfg_iters      = ITER_W'(1);
        cfg_start      = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0;
    endtask

    task automatic do_abort();
        int a;
        @(negedge ACLK);
        cfg_abort = 1'b1;
        a = cyc;
        for (int c = a + 1; c < NCYC; c++) begin
            exp_s[c] = 0; exp_r[c] = 0; exp_b[c] = 0; exp_d[c] = exp_d[a];
        end
        purge_after(a);
        @(negedge ACLK);
        cfg_abort = 1'b0;
    endtask

    task automatic do_reset();
        int a;
        @(negedge ACLK);
        ARESET = 1'b1;
        a = cyc;
        for (int c = a + 1; c < NCYC; c++) begin
            exp_s[c] = 0; exp_r[c] = 0; exp_b[c] = 0; exp_d[c] = 0;
        end
        purge_after(a);
        reset_at = a;
        @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge ACLK);
    endtask

    // Monitor: compares every cycle against the schedule and pops reports as they come due.
    initial begin
        logic [CNT_W-1:0]  last_cnt  = '0;
        logic [ITER_W-1:0] last_iter = '0;
        logic              last_ovf  = 1'b0;
        rep_t              r;
        forever begin
            @(negedge ACLK);
            if (cyc == reset_at + 1) begin
                last_cnt = '0; last_iter = '0; last_ovf = 1'b0;
            end
            checkOutput("phase{stress,ro,busy,done}", {stress_en, ro_en, busy, done},
                        {exp_s[cyc], exp_r[cyc], exp_b[cyc], exp_d[cyc]});
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                r = exp_q.pop_front();
                checkOutput("meas_valid", meas_valid, 1);
                checkOutput("meas_count", meas_count, r.cnt);
                checkOutput("meas_iter", meas_iter, r.iter);
                checkOutput("meas_ovf", meas_ovf, r.ovf);
                last_cnt = r.cnt; last_iter = r.iter; last_ovf = r.ovf;
            end else begin
                checkOutput("no_meas_valid", meas_valid, 0);
                checkOutput("meas_hold", {meas_count, meas_iter, meas_ovf},
                            {last_cnt, last_iter, last_ovf});
            end
        end
    end

    initial begin
        #(NCYC * 10);
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, last, s, g, it;
        ARESET = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_stress_len = '0; cfg_gate_len = '0; cfg_iters = '0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;

        $display("[TB] single run");
        applyStimulus(10, 100, 1, 0, 5, 0, t0, last);
        wait_until(last + 3);

        $display("[TB] three iterations, start and gate change while busy");
        applyStimulus(10, 100, 3, 0, 5, 0, t0, last);
        wait_until(t0 + 49);
        start_ignored();
        wait_until(last + 3);

        $display("[TB] overflow");
        applyStimulus(3, 200, 1, 0, 2, 0, t0, last);
        wait_until(last + 3);

        $display("[TB] zero lengths");
        applyStimulus(0, 0, 1, 0, 5, 0, t0, last);
        wait_until(last + 3);

        $display("[TB] abort mid-gate then rerun");
        applyStimulus(10, 100, 1, 0, 5, 0, t0, last);
        wait_until(t0 + 59);
        do_abort();
        wait_until(cyc + 3);
        applyStimulus(10, 100, 1, 0, 5, 0, t0, last);
        wait_until(last + 3);

        $display("[TB] start with abort in idle");
        @(negedge ACLK);
        cfg_start = 1'b1; cfg_abort = 1'b1;
        @(negedge ACLK);
        cfg_start = 1'b0; cfg_abort = 1'b0;
        wait_until(cyc + 5);

        $display("[TB] reset during stress");
        applyStimulus(20, 30, 2, 1, 0, 0, t0, last);
        wait_until(t0 + 4);
        do_reset();
        wait_until(cyc + 4);

        $display("[TB] continuous mode with index wrap");
        applyStimulus(0, 0, 0, 1, 0, 12, t0, last);
        wait_until(t0 + 185);
        do_abort();
        wait_until(cyc + 4);

        $display("[TB] randomized runs");
        for (int k = 0; k < 6; k++) begin
            s  = $urandom_range(0, 20);
            g  = $urandom_range(0, 40);
            it = $urandom_range(1, 3);
            applyStimulus(s, g, it, 1, 0, 0, t0, last);
            if ($urandom_range(0, 2) == 0) begin
                wait_until(t0 + $urandom_range(1, last - t0));
                do_abort();
                wait_until(cyc + 4);
            end else begin
                wait_until(last + 3);
            end
        end

        wait_until(cyc + 5);
        checkOutput("reports_outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
